pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Drives stall/flush inputs of every inter-stage register, e.g. the D→E register (flushE has priority over stallE there).
- Resolves load-use and mfc0-use hazards, branch mispredict, exceptions/eret, cache-busy stalls and the multi-cycle divider.
- Owns the divider sequencing FSM and a pending-redirect latch for exceptions raised while fetch is stalled.

---
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath (master) and
// the central stall/flush controller (slave).
interface pipeline_hazard_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] writeregE;
  logic       regwriteE;
  logic       mem_readE;
  logic       cp0_to_regE;
  logic       div_startE;
  logic       branch_mispredE;
  logic       exceptM;
  logic       i_stall;
  logic       d_stall;

  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       stallW;
  logic       flushD;
  logic       flushE;
  logic       flushM;
  logic       flushW;
  logic       div_busy;
  logic       div_doneE;

  modport master (
    output rsD, rtD, writeregE, regwriteE, mem_readE, cp0_to_regE,
           div_startE, branch_mispredE, exceptM, i_stall, d_stall,
    input  stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, div_busy, div_doneE
  );

  modport slave (
    input  rsD, rtD, writeregE, regwriteE, mem_readE, cp0_to_regE,
           div_startE, branch_mispredE, exceptM, i_stall, d_stall,
    output stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, div_busy, div_doneE
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the F/D/E/M/W pipeline, with divider
// sequencing FSM. Optional perf counters: define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } divState_t;

  divState_t      divState, divStateNext;
  logic [CNT_W-1:0] divCnt, divCntNext;
  logic           redirectPend, redirectPendNext;

  logic memStall;
  logic divStall;
  logic loadUse;
  logic redirectFlush;

  assign memStall = hz.i_stall | hz.d_stall;
  assign divStall = ((divState == DIV_IDLE) & hz.div_startE) | (divState == DIV_BUSY);
  assign loadUse  = (hz.mem_readE | hz.cp0_to_regE) & hz.regwriteE &
                    (hz.writeregE != 5'd0) &
                    ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD));
  // The stale-fetch discard waits until no cache stall holds D, so flushD
  // never collides with stallD.
  assign redirectFlush = redirectPend & ~memStall;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      divState     <= DIV_IDLE;
      divCnt       <= '0;
      redirectPend <= 1'b0;
    end else begin
      divState     <= divStateNext;
      divCnt       <= divCntNext;
      redirectPend <= redirectPendNext;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    divStateNext     = divState;
    divCntNext       = divCnt;
    redirectPendNext = redirectPend;

    if (hz.exceptM) begin
      divStateNext = DIV_IDLE;
      divCntNext   = '0;
    end else begin
      unique case (divState)
        DIV_IDLE: begin
          if (hz.div_startE) begin
            divStateNext = DIV_BUSY;
            divCntNext   = CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_BUSY: begin
          // Counter reaching zero ends BUSY: start cycle plus DIV_CYCLES-1
          // busy cycles gives exactly DIV_CYCLES stall cycles.
          divCntNext = divCnt - CNT_W'(1);
          if (divCnt == CNT_W'(1)) divStateNext = DIV_DONE;
        end
        DIV_DONE: begin
          if (!memStall) divStateNext = DIV_IDLE;
        end
        default: divStateNext = DIV_IDLE;
      endcase
    end

    if (hz.exceptM)         redirectPendNext = hz.i_stall;
    else if (redirectFlush) redirectPendNext = 1'b0;
  end

  always_comb begin
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.stallW    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushM    = 1'b0;
    hz.flushW    = 1'b0;
    hz.div_busy  = 1'b0;
    hz.div_doneE = 1'b0;

    if (!rst) begin
      hz.div_busy  = (divState != DIV_IDLE);
      hz.div_doneE = (divState == DIV_DONE);

      if (hz.exceptM) begin
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
        hz.flushM = 1'b1;
      end else if (memStall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
        hz.stallW = 1'b1;
      end else begin
        if (divStall) begin
          hz.stallF = 1'b1;
          hz.stallD = 1'b1;
          hz.stallE = 1'b1;
          hz.flushM = 1'b1;
        end else if (loadUse) begin
          hz.stallF = 1'b1;
          hz.stallD = 1'b1;
          hz.flushE = 1'b1;
        end else if (hz.branch_mispredE) begin
          hz.flushD = 1'b1;
        end

        // The pending redirect wins over D holds: D holds a wrong-path fetch.
        if (redirectFlush) begin
          hz.stallD = 1'b0;
          hz.flushD = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (hz.stallF)              stall_cycles <= stall_cycles + 32'd1;
      if (hz.flushE | hz.flushM)  flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (DIV_CYCLES=33).
// Output vector order: stallF stallD stallE stallM stallW flushD flushE flushM flushW div_busy div_doneE
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  pipeline_hazard_ctrl #(
    .DIV_CYCLES(33),
    .CNT_W     (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [10:0] O_NONE   = 11'b00000000000;
  localparam logic [10:0] O_LU     = 11'b11000010000;
  localparam logic [10:0] O_DIV0   = 11'b11100001000;
  localparam logic [10:0] O_DIVB   = 11'b11100001010;
  localparam logic [10:0] O_DONE   = 11'b00000000011;
  localparam logic [10:0] O_MEM    = 11'b11111000000;
  localparam logic [10:0] O_MEMB   = 11'b11111000010;
  localparam logic [10:0] O_EXC    = 11'b00000111000;
  localparam logic [10:0] O_EXCB   = 11'b00000111010;
  localparam logic [10:0] O_FD     = 11'b00000100000;

  function automatic logic [10:0] outs();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
            hz.flushD, hz.flushE, hz.flushM, hz.flushW, hz.div_busy, hz.div_doneE};
  endfunction

  task automatic clear_inputs();
    hz.rsD = 5'd0; hz.rtD = 5'd0; hz.writeregE = 5'd0;
    hz.regwriteE = 1'b0; hz.mem_readE = 1'b0; hz.cp0_to_regE = 1'b0;
    hz.div_startE = 1'b0; hz.branch_mispredE = 1'b0; hz.exceptM = 1'b0;
    hz.i_stall = 1'b0; hz.d_stall = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled 1ns later, well away from either clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    hz.exceptM = 1'b1; hz.i_stall = 1'b1; hz.div_startE = 1'b1;
    hz.mem_readE = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd3; hz.rsD = 5'd3;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      checks++;
      if (outs() !== O_NONE) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", c, outs(), O_NONE);
      end
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (outs() !== O_NONE) begin
      failures++;
      $display("FAIL reset_no_pend got=%b exp=%b", outs(), O_NONE);
    end
  endtask

  task automatic test_load_use();
    logic [10:0] exp;
    // {mem_readE, cp0_to_regE, regwriteE, writeregE, rsD, rtD} -> expected
    logic [20:0] vec [6];
    logic [10:0] vexp [6];
    vec[0] = {1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd7};  vexp[0] = O_LU;
    vec[1] = {1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0};  vexp[1] = O_NONE;
    vec[2] = {1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0};  vexp[2] = O_NONE;
    vec[3] = {1'b0, 1'b1, 1'b1, 5'd9, 5'd4, 5'd9};  vexp[3] = O_LU;
    vec[4] = {1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5};  vexp[4] = O_NONE;
    vec[5] = {1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd6};  vexp[5] = O_NONE;
    for (int i = 0; i < 6; i++) begin
      tick();
      clear_inputs();
      {hz.mem_readE, hz.cp0_to_regE, hz.regwriteE, hz.writeregE, hz.rsD, hz.rtD} = vec[i];
      #1;
      exp = vexp[i];
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL load_use vec=%0d got=%b exp=%b", i, outs(), exp);
      end
    end
    // Load-use under a cache stall: only the cache stall shows.
    tick();
    clear_inputs();
    hz.mem_readE = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd2; hz.rsD = 5'd2;
    hz.d_stall = 1'b1;
    #1;
    checks++;
    if (outs() !== O_MEM) begin
      failures++;
      $display("FAIL load_use_memstall got=%b exp=%b", outs(), O_MEM);
    end
    tick();
    clear_inputs();
  endtask

  // Runs one div; stallAt>0 pulses d_stall on that cycle.
  task automatic run_div(input string name, input int stallAt);
    logic [10:0] exp;
    int stallCount;
    stallCount = 0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      clear_inputs();
      hz.div_startE = (c <= 34);
      hz.d_stall    = (c == stallAt);
      #1;
      if (c == stallAt)  exp = O_MEMB;
      else if (c == 1)   exp = O_DIV0;
      else if (c <= 33)  exp = O_DIVB;
      else if (c == 34)  exp = O_DONE;
      else               exp = O_NONE;
      if (hz.stallF && c != stallAt) stallCount++;
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, c, outs(), exp);
      end
    end
    checks++;
    if (stallCount != ((stallAt > 0) ? 32 : 33)) begin
      failures++;
      $display("FAIL %s_stall_count got=%0d exp=%0d", name, stallCount, (stallAt > 0) ? 32 : 33);
    end
  endtask

  task automatic test_div();
    run_div("div", 0);
  endtask

  task automatic test_div_memstall();
    run_div("div_memstall", 10);
  endtask

  task automatic test_except_div();
    logic [10:0] exp;
    for (int c = 1; c <= 7; c++) begin
      tick();
      clear_inputs();
      hz.div_startE = (c <= 6);
      hz.exceptM    = (c == 6);
      #1;
      if (c == 1)      exp = O_DIV0;
      else if (c < 6)  exp = O_DIVB;
      else if (c == 6) exp = O_EXCB;
      else             exp = O_NONE;
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL except_div cyc=%0d got=%b exp=%b", c, outs(), exp);
      end
    end
  endtask

  task automatic test_except_istall();
    logic [10:0] exp;
    int flushCount;
    flushCount = 0;
    for (int c = 0; c <= 7; c++) begin
      tick();
      clear_inputs();
      hz.exceptM = (c == 0);
      hz.i_stall = (c <= 4);
      #1;
      if (c == 0)      exp = O_EXC;
      else if (c <= 4) exp = O_MEM;
      else if (c == 5) exp = O_FD;
      else             exp = O_NONE;
      if (c > 0 && hz.flushD) flushCount++;
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL except_istall cyc=%0d got=%b exp=%b", c, outs(), exp);
      end
    end
    checks++;
    if (flushCount != 1) begin
      failures++;
      $display("FAIL except_istall_pulses got=%0d exp=1", flushCount);
    end
  endtask

  task automatic test_mispredict();
    logic [10:0] exp;
    for (int c = 0; c <= 3; c++) begin
      tick();
      clear_inputs();
      hz.branch_mispredE = (c <= 1) || (c == 3);
      hz.d_stall         = (c == 0);
      hz.exceptM         = (c == 3);
      #1;
      if (c == 0)      exp = O_MEM;
      else if (c == 1) exp = O_FD;
      else if (c == 2) exp = O_NONE;
      else             exp = O_EXC;
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL mispredict cyc=%0d got=%b exp=%b", c, outs(), exp);
      end
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_div();
    test_div_memstall();
    test_except_div();
    test_except_istall();
    test_mispredict();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
